// File: rtl/if_id_skid_buffer.sv
// Two-entry elastic IF->ID register: head entry drives decode, skid entry absorbs
// one beat of decode stall so if_ready never depends on id_ready.
module if_id_skid_buffer #(
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 30,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 30'h1C000000,
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               if_valid,
    input  logic [PC_W-1:0]    if_pc,
    input  logic [INSTR_W-1:0] if_instr,
    output logic               if_ready,
    input  logic               flush,
    input  logic               id_ready,
    output logic               id_valid,
    output logic [PC_W-1:0]    id_pc,
    output logic [INSTR_W-1:0] id_instr,
    output logic [3:0]         id_opcode,
    output logic [CNT_W-1:0]   bubble_cnt
);

    logic [1:0]         count_p0;
    logic [1:0]         count_nxt;
    logic               vld_p0;
    logic [PC_W-1:0]    head_pc_p0;
    logic [INSTR_W-1:0] head_instr_p0;
    logic [PC_W-1:0]    skid_pc_p0;
    logic [INSTR_W-1:0] skid_instr_p0;
    logic               push;
    logic               pop;
    logic               load_head;
    logic               head_from_skid;
    logic               load_skid;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign vld_p0   = (count_p0 != 2'd0);
    assign if_ready = (count_p0 != 2'd2);
    assign id_valid = vld_p0;
    assign push     = if_valid && if_ready;
    assign pop      = vld_p0 && id_ready;

    always_comb begin
        load_head      = 1'b0;
        head_from_skid = 1'b0;
        load_skid      = 1'b0;
        count_nxt      = count_p0;
        case (count_p0)
            2'd0: begin
                if (push) begin
                    load_head = 1'b1;
                    count_nxt = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    load_head = 1'b1;
                end else if (push) begin
                    load_skid = 1'b1;
                    count_nxt = 2'd2;
                end else if (pop) begin
                    count_nxt = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    head_from_skid = 1'b1;
                    count_nxt      = 2'd1;
                end
            end
            default: count_nxt = 2'd0;
        endcase
        // Flush wins: any handshake this cycle still completes, but nothing survives.
        if (flush) begin
            count_nxt = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_p0   <= 2'd0;
            bubble_cnt <= '0;
        end else begin
            count_p0 <= count_nxt;
            if (!vld_p0) begin
                bubble_cnt <= sat_inc(bubble_cnt);
            end
        end
    end

    // ---- storage stage: data only, qualified by count_p0 ----
    always_ff @(posedge clk) begin
        if (load_head) begin
            head_pc_p0    <= if_pc;
            head_instr_p0 <= if_instr;
        end else if (head_from_skid) begin
            head_pc_p0    <= skid_pc_p0;
            head_instr_p0 <= skid_instr_p0;
        end
        if (load_skid) begin
            skid_pc_p0    <= if_pc;
            skid_instr_p0 <= if_instr;
        end
    end

    assign id_pc     = vld_p0 ? head_pc_p0 : '0;
    assign id_instr  = vld_p0 ? head_instr_p0 : NOP_INSTR;
    assign id_opcode = id_instr[29:26];

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// Bench for if_id_skid_buffer: per-cycle vector table for the directed corners,
// then a queue scoreboard for streaming/random traffic, plus a CNT_W=4 instance.
module tb_if_id_skid_buffer;

    localparam logic [29:0] NOP = 30'h1C000000;
    localparam logic [29:0] I0  = 30'h0880000F;
    localparam logic [29:0] I1  = 30'h0880000A;

    logic        clk = 1'b0;
    logic        rst, if_valid, flush, id_ready;
    logic [31:0] if_pc;
    logic [29:0] if_instr;
    logic        if_ready, id_valid;
    logic [31:0] id_pc;
    logic [29:0] id_instr;
    logic [3:0]  id_opcode;
    logic [15:0] bubble_cnt;

    logic        if_ready4, id_valid4;
    logic [31:0] id_pc4;
    logic [29:0] id_instr4;
    logic [3:0]  id_opcode4;
    logic [3:0]  bubble_cnt4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    if_id_skid_buffer dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .if_ready(if_ready), .flush(flush), .id_ready(id_ready), .id_valid(id_valid),
        .id_pc(id_pc), .id_instr(id_instr), .id_opcode(id_opcode), .bubble_cnt(bubble_cnt)
    );

    if_id_skid_buffer #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .if_ready(if_ready4), .flush(flush), .id_ready(id_ready), .id_valid(id_valid4),
        .id_pc(id_pc4), .id_instr(id_instr4), .id_opcode(id_opcode4), .bubble_cnt(bubble_cnt4)
    );

    typedef struct {
        string       name;
        logic        rst;
        logic        vin;
        logic [31:0] pc;
        logic [29:0] instr;
        logic        fl;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [29:0] einstr;
        logic        erdy;
        int          ebub;   // -1: not checked
    } vec_t;

    vec_t vt[$];

    task automatic add(string nm, logic r, logic vin, logic [31:0] pc, logic [29:0] ins,
                       logic fl, logic rdy, logic ev, logic [31:0] epc, logic [29:0] eins,
                       logic erdy, int ebub);
        vec_t v;
        v.name = nm; v.rst = r; v.vin = vin; v.pc = pc; v.instr = ins; v.fl = fl;
        v.rdy = rdy; v.ev = ev; v.epc = epc; v.einstr = eins; v.erdy = erdy; v.ebub = ebub;
        vt.push_back(v);
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(logic r, logic vin, logic [31:0] pc, logic [29:0] ins,
                         logic fl, logic rdy);
        rst = r; if_valid = vin; if_pc = pc; if_instr = ins; flush = fl; id_ready = rdy;
    endtask

    // Scoreboard: expected beats in FIFO order; the queue size is the model occupancy.
    logic [61:0] sbq[$];

    task automatic sb_cycle(logic vin, logic [31:0] pc, logic [29:0] ins, logic fl, logic rdy);
        bit m_push, m_pop;
        drive(1'b1, vin, pc, ins, fl, rdy);
        #1;
        chk("sb.if_ready", {63'b0, if_ready}, {63'b0, sbq.size() != 2});
        chk("sb.id_valid", {63'b0, id_valid}, {63'b0, sbq.size() != 0});
        m_push = vin && (sbq.size() != 2);
        m_pop  = (sbq.size() != 0) && rdy;
        if (m_pop) begin
            logic [61:0] e;
            e = sbq.pop_front();
            chk("sb.beat", {2'b0, id_pc, id_instr}, {2'b0, e});
        end
        if (m_push) sbq.push_back({pc, ins});
        if (fl) sbq.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] bub_ref;
        logic [29:0] tmp;
        drive(1'b0, 1'b1, 32'h4, I0, 1'b0, 1'b0);

        //   name          rst vin pc      instr fl rdy | ev epc    einstr erdy bub
        add("reset0",      0,  1,  32'h4,  I0,   0, 0,    0, 32'h0, NOP,   1,   0);
        add("reset1",      0,  1,  32'h4,  I0,   0, 0,    0, 32'h0, NOP,   1,   0);
        add("single.push", 1,  1,  32'h4,  I0,   0, 1,    1, 32'h4, I0,    1,   1);
        add("single.gone", 1,  0,  32'h0,  I1,   0, 1,    0, 32'h0, NOP,   1,   1);
        add("stall.p1",    1,  1,  32'h4,  I0,   0, 0,    1, 32'h4, I0,    1,   2);
        add("stall.p2",    1,  1,  32'h8,  I1,   0, 0,    1, 32'h4, I0,    0,   2);
        add("stall.pop1",  1,  1,  32'hC,  I0,   0, 1,    1, 32'h8, I1,    1,   2);
        add("stall.pop2",  1,  0,  32'h0,  I0,   0, 1,    0, 32'h0, NOP,   1,   2);
        add("fl.fill1",    1,  1,  32'h10, I0,   0, 0,    1, 32'h10, I0,   1,  -1);
        add("fl.fill2",    1,  1,  32'h14, I1,   0, 0,    1, 32'h10, I0,   0,  -1);
        add("fl.full",     1,  1,  32'h18, I0,   1, 0,    0, 32'h0, NOP,   1,  -1);
        add("fl.emptypush",1,  1,  32'h1C, I1,   1, 1,    0, 32'h0, NOP,   1,  -1);
        add("fl.after",    1,  0,  32'h0,  I0,   0, 1,    0, 32'h0, NOP,   1,  -1);
        add("fl1.fill",    1,  1,  32'h20, I0,   0, 0,    1, 32'h20, I0,   1,  -1);
        add("fl1.pushpop", 1,  1,  32'h24, I1,   1, 1,    0, 32'h0, NOP,   1,  -1);
        add("fl1.after",   1,  0,  32'h0,  I0,   0, 1,    0, 32'h0, NOP,   1,  -1);
        add("pp.fill",     1,  1,  32'h28, I0,   0, 1,    1, 32'h28, I0,   1,  -1);
        add("pp.swap",     1,  1,  32'h2C, I1,   0, 1,    1, 32'h2C, I1,   1,  -1);
        add("pp.drain",    1,  0,  32'h0,  I0,   0, 1,    0, 32'h0, NOP,   1,  -1);
        add("mr.fill1",    1,  1,  32'h30, I0,   0, 0,    1, 32'h30, I0,   1,  -1);
        add("mr.fill2",    1,  1,  32'h34, I1,   0, 0,    1, 32'h30, I0,   0,  -1);
        add("mr.reset",    0,  0,  32'h0,  I0,   0, 0,    0, 32'h0, NOP,   1,   0);
        add("mr.idle",     1,  0,  32'h0,  I0,   0, 1,    0, 32'h0, NOP,   1,   1);

        foreach (vt[i]) begin
            drive(vt[i].rst, vt[i].vin, vt[i].pc, vt[i].instr, vt[i].fl, vt[i].rdy);
            @(posedge clk);
            #1;
            tmp = vt[i].einstr;
            chk({vt[i].name, ".id_valid"}, {63'b0, id_valid}, {63'b0, vt[i].ev});
            chk({vt[i].name, ".id_pc"}, {32'b0, id_pc}, {32'b0, vt[i].epc});
            chk({vt[i].name, ".id_instr"}, {34'b0, id_instr}, {34'b0, vt[i].einstr});
            chk({vt[i].name, ".id_opcode"}, {60'b0, id_opcode}, {60'b0, tmp[29:26]});
            chk({vt[i].name, ".if_ready"}, {63'b0, if_ready}, {63'b0, vt[i].erdy});
            if (vt[i].ebub >= 0)
                chk({vt[i].name, ".bubble_cnt"}, {48'b0, bubble_cnt}, 64'(vt[i].ebub));
        end

        // Streaming: buffer empty here; first edge pushes into an empty buffer.
        sbq.delete();
        sb_cycle(1'b1, 32'h0, 30'h0880_0000, 1'b0, 1'b1);
        bub_ref = bubble_cnt;
        for (int k = 1; k < 8; k++)
            sb_cycle(1'b1, 32'(k * 4), 30'h0880_0000 | 30'(k), 1'b0, 1'b1);
        chk("stream.bubble_cnt", {48'b0, bubble_cnt}, {48'b0, bub_ref});
        sb_cycle(1'b0, 32'h0, I0, 1'b0, 1'b1);
        chk("stream.drained", 64'(sbq.size()), 64'd0);

        // Random traffic with occasional flush against the scoreboard.
        for (int k = 0; k < 300; k++)
            sb_cycle($urandom_range(0, 3) != 0, 32'h1000 + 32'(k * 4), 30'($urandom),
                     $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
        for (int k = 0; k < 3; k++)
            sb_cycle(1'b0, 32'h0, I0, 1'b0, 1'b1);
        chk("random.drained", 64'(sbq.size()), 64'd0);

        // Saturation on the CNT_W=4 instance.
        drive(1'b0, 1'b0, 32'h0, I0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("sat.reset", {60'b0, bubble_cnt4}, 64'd0);
        drive(1'b1, 1'b0, 32'h0, I0, 1'b0, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 15) chk("sat.at15", {60'b0, bubble_cnt4}, 64'd15);
        end
        chk("sat.at20", {60'b0, bubble_cnt4}, 64'd15);
        chk("sat.wide20", {48'b0, bubble_cnt}, 64'd20);
        chk("sat.idle_nop", {34'b0, id_instr4}, {34'b0, NOP});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
